// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: word-array memory behind the LC-3b memory interface.
// Services one read/write at a time after DELAY cycles, single-cycle mem_resp.
module lc3b_mem_responder #(
    parameter int DELAY     = 3,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic        proto_err
);
    localparam int DEPTH = 2**ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(DELAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t               state, state_nx;
    logic [3:0]           cnt, cnt_nx;
    logic                 op_rd, op_rd_nx;
    logic [ADDR_BITS-1:0] idx, idx_nx;
    logic [15:0]          wdata_q, wdata_nx;
    logic [1:0]           be_q, be_nx;
    logic                 err_set;
    logic                 enter_resp;
    logic [15:0]          mem [DEPTH];

    // Byte-select bit and aliased upper bits take no part in indexing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[15:ADDR_BITS+1],
                                mem_address[0]};

    assign enter_resp = (state_nx == RESP);

    // Next-state: accept in IDLE, count down or abort in BUSY.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_rd_nx = op_rd;
        idx_nx   = idx;
        wdata_nx = wdata_q;
        be_nx    = be_q;
        err_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    op_rd_nx = mem_read;
                    idx_nx   = mem_address[ADDR_BITS:1];
                    wdata_nx = mem_wdata;
                    be_nx    = mem_byte_enable;
                    cnt_nx   = CNT_LOAD;
                    err_set  = mem_read && mem_write;
                    state_nx = (DELAY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (op_rd ? !mem_read : !mem_write) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                    err_set  = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state_nx = RESP;
                    end
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Control state, latched request and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_rd     <= 1'b0;
            idx       <= '0;
            wdata_q   <= 16'h0000;
            be_q      <= 2'b00;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            op_rd     <= op_rd_nx;
            idx       <= idx_nx;
            wdata_q   <= wdata_nx;
            be_q      <= be_nx;
            proto_err <= proto_err | err_set;
        end
    end

    // Registered response pulse and read data captured entering RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_resp  <= 1'b0;
            mem_rdata <= 16'h0000;
        end else begin
            mem_resp <= enter_resp;
            if (enter_resp && op_rd_nx) begin
                mem_rdata <= mem[idx_nx];
            end
        end
    end

    // Lane-masked array write on the edge entering RESP; no reset of contents.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && !op_rd_nx) begin
            if (be_nx[0]) begin
                mem[idx_nx][7:0] <= wdata_nx[7:0];
            end
            if (be_nx[1]) begin
                mem[idx_nx][15:8] <= wdata_nx[15:8];
            end
        end
    end
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb_lc3b_mem_responder: directed and randomized checks of the responder
// against a word-array reference model, with a DELAY=1 second instance.
module tb_lc3b_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_byte_enable = 2'b00;
    logic [15:0] mem_address = 16'h0000;
    logic [15:0] mem_wdata = 16'h0000;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        proto_err;

    logic        r1_read = 1'b0;
    logic        r1_write = 1'b0;
    logic [1:0]  r1_be = 2'b00;
    logic [15:0] r1_addr = 16'h0000;
    logic [15:0] r1_wdata = 16'h0000;
    logic        r1_resp;
    logic [15:0] r1_rdata;
    logic        r1_err;

    int errors = 0;
    int checks = 0;

    logic [15:0] ref_mem [256];

    always #5 clk = ~clk;

    lc3b_mem_responder #(.DELAY(3), .ADDR_BITS(8)) dut (
        .clk(clk),
        .rst(rst),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_resp(mem_resp),
        .mem_rdata(mem_rdata),
        .proto_err(proto_err)
    );

    lc3b_mem_responder #(.DELAY(1), .ADDR_BITS(8)) dut1 (
        .clk(clk),
        .rst(rst),
        .mem_read(r1_read),
        .mem_write(r1_write),
        .mem_byte_enable(r1_be),
        .mem_address(r1_addr),
        .mem_wdata(r1_wdata),
        .mem_resp(r1_resp),
        .mem_rdata(r1_rdata),
        .proto_err(r1_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        mem_read = 1'b0;
        mem_write = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issue one request, hold it until mem_resp, drop it the cycle after.
    // lat = cycles from request cycle to resp cycle, -1 on timeout.
    task automatic do_op(input bit rd, input bit wr,
                         input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] be, output int lat,
                         output logic [15:0] q, output logic after);
        @(posedge clk);
        #1;
        mem_read = rd;
        mem_write = wr;
        mem_address = a;
        mem_wdata = d;
        mem_byte_enable = be;
        lat = -1;
        q = 16'hxxxx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_resp === 1'b1) begin
                lat = i;
                q = mem_rdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        after = mem_resp;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: got %b want 0", mem_resp);
        end
        checks++;
        if (mem_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0000", mem_rdata);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b want 0", proto_err);
        end
    endtask

    task automatic test_write_read();
        int lat;
        logic [15:0] q;
        logic after;
        do_op(0, 1, 16'h0010, 16'hBEEF, 2'b11, lat, q, after);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL wr_latency: got %0d want 3", lat);
        end
        checks++;
        if (after !== 1'b0) begin
            errors++;
            $display("FAIL wr_pulse_width: resp=%b after resp, want 0", after);
        end
        do_op(1, 0, 16'h0010, 16'h0000, 2'b00, lat, q, after);
        checks++;
        if (lat != 3 || q !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_beef: lat=%0d data=%h want 3/BEEF", lat, q);
        end
    endtask

    task automatic test_byte_lanes();
        int lat;
        logic [15:0] q;
        logic after;
        do_op(0, 1, 16'h0020, 16'h1234, 2'b11, lat, q, after);
        do_op(0, 1, 16'h0021, 16'hAB00, 2'b10, lat, q, after);
        do_op(1, 0, 16'h0020, 16'h0000, 2'b00, lat, q, after);
        checks++;
        if (q !== 16'hAB34) begin
            errors++;
            $display("FAIL lane_hi: got %h want AB34", q);
        end
        do_op(0, 1, 16'h0020, 16'h00CD, 2'b01, lat, q, after);
        do_op(1, 0, 16'h0020, 16'h0000, 2'b00, lat, q, after);
        checks++;
        if (q !== 16'hABCD) begin
            errors++;
            $display("FAIL lane_lo: got %h want ABCD", q);
        end
        do_op(0, 1, 16'h0020, 16'hFFFF, 2'b00, lat, q, after);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL be00_resp: latency %0d want 3", lat);
        end
        do_op(1, 0, 16'h0020, 16'h0000, 2'b00, lat, q, after);
        checks++;
        if (q !== 16'hABCD) begin
            errors++;
            $display("FAIL be00_data: got %h want ABCD", q);
        end
    endtask

    task automatic test_addr_hold();
        int lat;
        logic [15:0] q;
        logic after;
        do_op(0, 1, 16'h0030, 16'hC0DE, 2'b11, lat, q, after);
        @(posedge clk);
        #1;
        mem_read = 1'b1;
        mem_address = 16'h0010;
        @(posedge clk);
        #1;
        mem_address = 16'h0030;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_resp === 1'b1) begin
                lat = i;
                q = mem_rdata;
                break;
            end
        end
        @(posedge clk);
        #1 mem_read = 1'b0;
        checks++;
        if (lat < 0 || q !== 16'hBEEF) begin
            errors++;
            $display("FAIL addr_hold: lat=%0d data=%h want BEEF", lat, q);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] q;
        logic after;
        logic [7:0] idx;
        logic [15:0] a;
        logic [15:0] v;
        logic [1:0] be;
        bit wr;
        bit have_rd;
        logic [15:0] last_rd;
        for (int k = 0; k < 16; k++) begin
            idx = 8'h80 + 8'(k);
            v = 16'($urandom);
            a = {7'($urandom), idx, 1'b0};
            do_op(0, 1, a, v, 2'b11, lat, q, after);
            ref_mem[idx] = v;
        end
        have_rd = 1'b0;
        last_rd = 16'h0000;
        for (int k = 0; k < 40; k++) begin
            idx = 8'h80 + 8'($urandom_range(0, 15));
            a = {7'($urandom), idx, 1'($urandom)};
            v = 16'($urandom);
            be = 2'($urandom);
            wr = 1'($urandom);
            do_op(!wr, wr, a, v, be, lat, q, after);
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL rnd_latency[%0d]: got %0d want 3", k, lat);
            end
            if (wr) begin
                if (be[0]) ref_mem[idx][7:0] = v[7:0];
                if (be[1]) ref_mem[idx][15:8] = v[15:8];
                if (have_rd) begin
                    checks++;
                    if (q !== last_rd) begin
                        errors++;
                        $display("FAIL rnd_rdata_hold[%0d]: got %h want %h",
                                 k, q, last_rd);
                    end
                end
            end else begin
                checks++;
                if (q !== ref_mem[idx]) begin
                    errors++;
                    $display("FAIL rnd_read[%0d] a=%h: got %h want %h",
                             k, a, q, ref_mem[idx]);
                end
                last_rd = ref_mem[idx];
                have_rd = 1'b1;
            end
        end
    endtask

    task automatic test_both();
        int lat;
        logic [15:0] q;
        logic after;
        do_op(0, 1, 16'h0050, 16'h5555, 2'b11, lat, q, after);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clean: got %b want 0", proto_err);
        end
        do_op(1, 1, 16'h0050, 16'hAAAA, 2'b11, lat, q, after);
        checks++;
        if (q !== 16'h5555 || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL both_high: data=%h err=%b want 5555/1",
                     q, proto_err);
        end
        do_op(1, 0, 16'h0050, 16'h0000, 2'b00, lat, q, after);
        checks++;
        if (q !== 16'h5555) begin
            errors++;
            $display("FAIL both_no_write: got %h want 5555", q);
        end
    endtask

    task automatic test_alias();
        int lat;
        logic [15:0] q;
        logic after;
        do_op(0, 1, 16'h0202, 16'h7777, 2'b11, lat, q, after);
        do_op(1, 0, 16'h0002, 16'h0000, 2'b00, lat, q, after);
        checks++;
        if (q !== 16'h7777) begin
            errors++;
            $display("FAIL alias_0202: got %h want 7777", q);
        end
        do_op(0, 1, 16'hFFFE, 16'h3C3C, 2'b11, lat, q, after);
        do_op(1, 0, 16'h01FF, 16'h0000, 2'b00, lat, q, after);
        checks++;
        if (q !== 16'h3C3C) begin
            errors++;
            $display("FAIL alias_fffe: got %h want 3C3C", q);
        end
    endtask

    task automatic test_drop();
        int lat;
        logic [15:0] q;
        logic after;
        int seen;
        apply_reset();
        @(posedge clk);
        #1;
        mem_read = 1'b1;
        mem_address = 16'h0010;
        @(posedge clk);
        #1 mem_read = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_resp === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL drop_no_resp: %0d resp pulses want 0", seen);
        end
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL drop_err: got %b want 1", proto_err);
        end
        do_op(1, 0, 16'h0010, 16'h0000, 2'b00, lat, q, after);
        checks++;
        if (lat != 3 || q !== 16'hBEEF) begin
            errors++;
            $display("FAIL drop_recover: lat=%0d data=%h want 3/BEEF",
                     lat, q);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [15:0] q;
        logic after;
        do_op(0, 1, 16'h0040, 16'h1111, 2'b11, lat, q, after);
        do_op(1, 0, 16'h0040, 16'h0000, 2'b00, lat, q, after);
        @(posedge clk);
        #1;
        mem_write = 1'b1;
        mem_address = 16'h0040;
        mem_wdata = 16'h2222;
        mem_byte_enable = 2'b11;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (mem_resp !== 1'b0 || mem_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_outputs: resp=%b rdata=%h want 0/0000",
                     mem_resp, mem_rdata);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_err: got %b want 0", proto_err);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        rst = 1'b0;
        do_op(1, 0, 16'h0040, 16'h0000, 2'b00, lat, q, after);
        checks++;
        if (q !== 16'h1111) begin
            errors++;
            $display("FAIL rst_mid_nowrite: got %h want 1111", q);
        end
    endtask

    task automatic test_delay1();
        logic pat [6];
        @(posedge clk);
        #1;
        r1_read = 1'b1;
        r1_addr = 16'h0010;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[i] = r1_resp;
        end
        @(posedge clk);
        #1 r1_read = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (pat[i] !== 1'((i % 2) == 1)) begin
                errors++;
                $display("FAIL d1_resp[%0d]: got %b want %b",
                         i, pat[i], (i % 2) == 1);
            end
        end
        checks++;
        if (r1_err !== 1'b0) begin
            errors++;
            $display("FAIL d1_err: got %b want 0", r1_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_addr_hold();
        test_random();
        test_both();
        test_alias();
        test_drop();
        test_reset_mid();
        test_delay1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lc3b_mem_responder.md
Name: lc3b_mem_responder

Overview:
- Synthesizable memory-side responder for the LC-3b CPU memory interface (mem_read/mem_write/mem_byte_enable/mem_resp).
- Accepts one request at a time from the control FSM and services it from an internal word array after a programmable latency.
- Returns a single-cycle mem_resp. Used as the bench/FPGA memory behind the datapath.

Parameters:
DELAY, 3, cycles from request acceptance to mem_resp; legal range 1..15
ADDR_BITS, 8, word-array index width; depth = 2**ADDR_BITS 16-bit words

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
mem_read  in  1  read request, held until mem_resp seen
mem_write  in  1  write request, held until mem_resp seen
mem_byte_enable  in  2  write lane strobes; [0]=bits 7:0, [1]=bits 15:8
mem_address  in  16  byte address; bit 0 ignored
mem_wdata  in  16  write data
mem_resp  out  1  one-cycle completion pulse
mem_rdata  out  16  read data, valid in the mem_resp cycle
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset: state=IDLE, mem_resp=0, mem_rdata=16'h0000, proto_err=0, counter=0. Array contents are not reset. Reset mid-transaction discards the pending op; no array write occurs.
- FSM states:
  - IDLE:
    - mem_read or mem_write high at the edge: latch op, address, wdata and byte_enable; load counter=DELAY-1; go to BUSY, or to RESP directly if DELAY=1.
    - Both mem_read and mem_write high: treat as read, set proto_err.
  - BUSY:
    - Counter decrements each cycle; at 0, go to RESP.
    - If the latched op's request line is low at an edge (request dropped), abort to IDLE with no write and no resp, and set proto_err.
  - RESP: mem_resp=1 for exactly this cycle. Go unconditionally to IDLE on the next edge; requests are not sampled in RESP.
- Action on the edge entering RESP:
  - Read: mem_rdata <= array[idx].
  - Write: array[idx] lanes updated per latched byte_enable. be=2'b00 writes nothing but still responds. mem_rdata unchanged.
- Latency: request first high in cycle N gives mem_resp high in cycle N+DELAY. Back-to-back: the next request is accepted no earlier than the first IDLE cycle after RESP, so throughput is 1 op per DELAY+1 cycles.
- Address and data are latched at acceptance. Later changes to mem_address, mem_wdata or byte_enable during BUSY are ignored.
- idx = latched mem_address[ADDR_BITS:1]. Higher address bits are ignored (aliasing wrap). Address FFFE maps to idx 2**ADDR_BITS-1.
- mem_rdata holds its last read value outside RESP cycles.
- mem_resp and mem_rdata are registered; there are no combinational paths from inputs to outputs.
- proto_err clears only on rst.
- The initiator is required to deassert its request in the cycle after mem_resp. A request still high in IDLE is treated as a new request.

Test Plan:
- Reset, then DELAY=3, write addr 16'h0010, wdata 16'hBEEF, be=11 held → mem_resp high exactly 3 cycles after request; a following read of 0010 → mem_rdata=BEEF in its resp cycle.
- Preload 0020=1234; write 16'hAB00 be=10 to 0021, then read 0020 → mem_rdata=AB34; write 16'h00CD be=01 → 16'hABCD; be=00 write → value unchanged, mem_resp still pulses.
- DELAY=1: read request in cycle N → mem_resp in N+1. Hold mem_read high through a second cycle → second resp in N+3, one pulse each, never two consecutive resp cycles.
- Change mem_address from 0010 to 0030 during BUSY → data returned from 0010. Drop mem_read mid-BUSY → no resp, FSM back to IDLE, proto_err=1.
- mem_read and mem_write both high → read performed, array unchanged, proto_err=1. With ADDR_BITS=8, write to 16'h0202 then read 16'h0002 → same word (aliasing).
- Assert rst two cycles into a write to 0040 → mem_resp=0 and mem_rdata=0 immediately. Subsequent read of 0040 → old value preserved.
